// File: rtl/signed_seq_divider.sv
// -----------------------------------------------------------------------------
// signed_seq_divider
//
// Iterative signed divider: a 2W-bit two's-complement dividend divided by a
// W-bit two's-complement divisor. The quotient is truncated toward zero and
// saturated to W bits. The remainder takes the sign of the dividend. The
// divider retires one restoring-division step per clock, so a result takes
// 2W+2 edges from the accepting edge to the done pulse.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset (aborts any operation)
//   start      in   1    request, only sampled while busy is low
//   dividend   in   2W   two's-complement dividend, sampled with start
//   divisor    in   W    two's-complement divisor, sampled with start
//   busy       out  1    high through the RUN and FIX cycles
//   done       out  1    one-cycle pulse; results valid from this cycle on
//   quotient   out  W    signed, truncated toward zero, saturated
//   remainder  out  W    signed, sign follows the dividend
//   ovf        out  1    true quotient does not fit in W signed bits
//   dz         out  1    divisor was zero
// -----------------------------------------------------------------------------
module signed_seq_divider #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             ovf,
    output logic             dz
);

    localparam int CW = $clog2(2 * W);

    // Largest quotient magnitudes that still fit in W signed bits.
    localparam logic [2*W-1:0] POS_LIM = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [2*W-1:0] NEG_LIM = {{W{1'b0}}, 1'b1, {(W - 1){1'b0}}};

    // Saturation values.
    localparam logic [W-1:0] QMAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] QMIN = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    dq_q;        // dividend magnitude shifting out, quotient bits shifting in
    logic [W-1:0]      rem_q;       // partial remainder magnitude, always < |divisor|
    logic [W:0]        dvs_q;       // divisor magnitude (W+1 bits so -2^(W-1) is exact)
    logic              dvd_neg_q;
    logic              dvs_neg_q;
    logic              dz_flag_q;
    logic [W-1:0]      dvd_lo_q;    // raw low dividend bits, returned as remainder on divide-by-zero

    logic              busy_q;
    logic              done_q;
    logic [W-1:0]      quot_q;
    logic [W-1:0]      rem_out_q;
    logic              ovf_q;
    logic              dz_q;

    // ---------------------------------------------------------------------
    // Operand magnitudes at load time.
    // The unsigned 2W-bit negation of -2^(2W-1) is 2^(2W-1), which is the
    // correct magnitude, so no extra dividend bit is needed in the shifter.
    // ---------------------------------------------------------------------
    logic [2*W-1:0]    dvd_abs;
    logic [W:0]        dvs_sext;
    logic [W:0]        dvs_abs;

    assign dvd_abs  = dividend[2*W-1] ? -dividend : dividend;
    assign dvs_sext = {divisor[W-1], divisor};
    assign dvs_abs  = divisor[W-1] ? -dvs_sext : dvs_sext;

    // ---------------------------------------------------------------------
    // One restoring step: bring in the next dividend bit and trial-subtract.
    // Whether the difference is kept or the shifted value is restored, the
    // result is below |divisor| <= 2^(W-1), so it fits back into W bits.
    // ---------------------------------------------------------------------
    logic [W:0]        shifted;
    logic              trial_ok;
    logic [W-1:0]      rem_d;

    assign shifted  = {rem_q, dq_q[2*W-1]};
    assign trial_ok = (shifted >= dvs_q);
    assign rem_d    = trial_ok ? W'(shifted - dvs_q) : W'(shifted);

    // ---------------------------------------------------------------------
    // Sign fix-up and saturation of the finished magnitudes.
    // A negative quotient may reach magnitude 2^(W-1); a positive one only
    // 2^(W-1)-1.
    // ---------------------------------------------------------------------
    logic              q_neg;
    logic              ovf_d;
    logic [W-1:0]      quot_d;
    logic [W-1:0]      rem_out_d;

    assign q_neg     = dvd_neg_q ^ dvs_neg_q;
    assign ovf_d     = q_neg ? (dq_q > NEG_LIM) : (dq_q > POS_LIM);
    assign quot_d    = ovf_d ? (q_neg ? QMIN : QMAX)
                             : (q_neg ? W'(-dq_q) : dq_q[W-1:0]);
    assign rem_out_d = dvd_neg_q ? -rem_q : rem_q;

    // ---------------------------------------------------------------------
    // Control FSM, datapath and registered outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dz_flag_q <= 1'b0;
            dvd_lo_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                // DONE accepts a new start exactly like IDLE, which gives
                // back-to-back operation when start is held high.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_neg_q <= dividend[2*W-1];
                        dvs_neg_q <= divisor[W-1];
                        dq_q      <= dvd_abs;
                        dvs_q     <= dvs_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        dz_flag_q <= (divisor == '0);
                        dvd_lo_q  <= dividend[W-1:0];
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end

                RUN: begin
                    dq_q  <= {dq_q[2*W-2:0], trial_ok};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(2 * W - 1)) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    if (dz_flag_q) begin
                        quot_q    <= '0;
                        rem_out_q <= dvd_lo_q;
                        ovf_q     <= 1'b0;
                        dz_q      <= 1'b1;
                    end else begin
                        quot_q    <= quot_d;
                        rem_out_q <= rem_out_d;
                        ovf_q     <= ovf_d;
                        dz_q      <= 1'b0;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_out_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_seq_divider
//
// Drives signed divisions into signed_seq_divider. Each accepted request pushes
// its expected result and done edge onto a scoreboard. A monitor pops and
// compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_signed_seq_divider;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             ovf;
    logic             dz;

    signed_seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           o;
        logic           z;
        int             cyc;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;
    int cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent reference: integer division truncates toward zero and
    // the remainder keeps the dividend's sign.
    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        int   qt;
        int   rt;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.a = a;
        e.b = b;
        e.cyc = 0;
        if (bi == 0) begin
            e.q = '0;
            e.r = a[W-1:0];
            e.o = 1'b0;
            e.z = 1'b1;
        end else begin
            qt = ai / bi;
            rt = ai % bi;
            e.z = 1'b0;
            if (qt > 127) begin
                e.q = 8'h7F;
                e.o = 1'b1;
            end else if (qt < -128) begin
                e.q = 8'h80;
                e.o = 1'b1;
            end else begin
                e.q = qt[W-1:0];
                e.o = 1'b0;
            end
            e.r = rt[W-1:0];
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest scoreboard entry.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                n_txn++;
                check_val("quotient",  32'(quotient),  32'(e.q));
                check_val("remainder", 32'(remainder), 32'(e.r));
                check_val("ovf",       32'(ovf),       32'(e.o));
                check_val("dz",        32'(dz),        32'(e.z));
                check_val("busy_in_done", 32'(busy),   32'd0);
                check_val("latency",   32'(cyc),       32'(e.cyc));
                $display("[TB] txn %0d: %0d / %0d -> q=%02h r=%02h ovf=%0b dz=%0b (exp q=%02h r=%02h ovf=%0b dz=%0b)",
                         n_txn, $signed(e.a), $signed(e.b), quotient, remainder, ovf, dz,
                         e.q, e.r, e.o, e.z);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check_val("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Issue one division with a single-cycle start pulse and wait for it.
    task automatic do_div(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic o, input logic z);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.a = a; e.b = b; e.q = q; e.r = r; e.o = o; e.z = z;
        e.cyc = cyc + 18;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", 32'(busy), 32'd1);
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy),      32'd0);
        check_val({tag, "_done"}, 32'(done),      32'd0);
        check_val({tag, "_quot"}, 32'(quotient),  32'd0);
        check_val({tag, "_rem"},  32'(remainder), 32'd0);
        check_val({tag, "_ovf"},  32'(ovf),       32'd0);
        check_val({tag, "_dz"},   32'(dz),        32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        exp_t e;
        int   c0;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Directed cases.
        do_div(16'h3F01, 8'd127, 8'd127, 8'h00, 1'b0, 1'b0);
        do_div(16'hFC7C, 8'd7,   8'h80,  8'hFC, 1'b0, 1'b0);
        do_div(16'hC000, 8'h80,  8'h7F,  8'h00, 1'b1, 1'b0);
        do_div(16'h8000, 8'hFF,  8'h7F,  8'h00, 1'b1, 1'b0);
        do_div(16'h01F4, 8'h00,  8'h00,  8'hF4, 1'b0, 1'b1);

        // Back-to-back: start held through done, second request accepted in
        // the done cycle; operands changed while busy must not be re-sampled.
        @(negedge clk);
        c0 = cyc;
        dividend = 16'd1000; divisor = 8'hF7; start = 1'b1;
        e.a = 16'd1000; e.b = 8'hF7; e.q = 8'h91; e.r = 8'h01; e.o = 1'b0; e.z = 1'b0;
        e.cyc = c0 + 18;
        sb.push_back(e);
        @(negedge clk);
        dividend = 16'd1000; divisor = 8'd9;
        e.a = 16'd1000; e.b = 8'd9; e.q = 8'h6F; e.r = 8'h01; e.o = 1'b0; e.z = 1'b0;
        e.cyc = c0 + 36;
        sb.push_back(e);
        for (int i = 0; i < 40 && cyc < c0 + 19; i++) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start pulse mid-RUN with other operands is ignored.
        @(negedge clk);
        dividend = 16'd100; divisor = 8'd3; start = 1'b1;
        e.a = 16'd100; e.b = 8'd3; e.q = 8'd33; e.r = 8'd1; e.o = 1'b0; e.z = 1'b0;
        e.cyc = cyc + 18;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'd5; divisor = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset 5 cycles into RUN aborts with no done pulse.
        @(negedge clk);
        dividend = 16'd1234; divisor = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        repeat (25) @(negedge clk);
        check_val("abort_idle_busy", 32'(busy), 32'd0);

        do_div(16'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0);

        // rst wins over start on the same edge.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 16'd50; divisor = 8'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_all_zero("rst_prio");
        repeat (22) @(negedge clk);

        // Random operands against the reference model, with a few biased
        // toward the extremes.
        for (int i = 0; i < 24; i++) begin
            logic [2*W-1:0] ra;
            logic [W-1:0]   rb;
            ra = 16'($urandom);
            rb = 8'($urandom);
            if (i % 6 == 1) rb = 8'h80;
            if (i % 6 == 2) ra = 16'h8000;
            if (i % 6 == 3) rb = 8'h00;
            if (i % 6 == 4) ra = {{8{ra[7]}}, ra[7:0]};
            e = model(ra, rb);
            do_div(ra, rb, e.q, e.r, e.o, e.z);
        end

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
